// File: rtl/flappy_pkg.sv
// Shared types for the flappy display path: the 8x8 pipe frame layout and
// the row-scan phase encoding.
package flappy_pkg;

   localparam int MATRIX_DIM = 8;

   // frame[c][r]: column c (0 = leftmost), row r (0 = top)
   typedef logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0] matrix_t;

   typedef enum logic {
      PH_BLANK = 1'b0,
      PH_DRIVE = 1'b1
   } scan_phase_e;

endpackage

// File: rtl/led_matrix_scan_if.sv
// Frame/bird inputs and LED matrix drive lines of the row scanner.
interface led_matrix_scan_if;
   import flappy_pkg::*;

   logic       enable;
   matrix_t    pipes;
   logic [2:0] bird_row;
   logic       bird_en;
   logic [7:0] row_sel;
   logic [7:0] red_col;
   logic [7:0] grn_col;
   logic       frame_done;

   modport master (
      output enable, pipes, bird_row, bird_en,
      input  row_sel, red_col, grn_col, frame_done
   );

   modport slave (
      input  enable, pipes, bird_row, bird_en,
      output row_sel, red_col, grn_col, frame_done
   );

endinterface

// File: rtl/matrix_row_slice.sv
// Transpose slice: picks one row out of a column-ordered frame as a column
// vector (bit c = column c).
module matrix_row_slice
   import flappy_pkg::*;
(
   input  matrix_t                 frame,
   input  logic [2:0]              row,
   output logic [MATRIX_DIM-1:0]   col
);

   for (genvar c = 0; c < MATRIX_DIM; c++) begin : g_col
      assign col[c] = frame[c][row];
   end

endmodule

// File: rtl/led_matrix_scan.sv
// Time-multiplexed row scanner for the dual-colour 8x8 matrix: pipes on red,
// bird on green, frame snapshotted at the start of each scan so it never tears.
module led_matrix_scan
   import flappy_pkg::*;
#(
   parameter int DWELL    = 1024,
   parameter int BLANK    = 16,
   parameter int BIRD_COL = 1
) (
   input  logic             clk,
   input  logic             reset,
   led_matrix_scan_if.slave bus
);

   localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   scan_phase_e      phase_q, phase_d;
   logic [2:0]       row_q, row_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   matrix_t          frame_q, frame_d;
   logic [2:0]       bird_row_q, bird_row_d;
   logic             bird_en_q, bird_en_d;

   logic             capture;
   logic             last_blank;
   logic             last_drive;
   logic [7:0]       red_slice;

   // Capture point is the very first cycle of a scan, so the buffer is
   // settled long before row 0 is driven.
   assign capture    = bus.enable && (phase_q == PH_BLANK) &&
                       (row_q == 3'd0) && (cnt_q == '0);
   assign last_blank = (cnt_q == CNT_W'(BLANK - 1));
   assign last_drive = (cnt_q == CNT_W'(DWELL - 1));

   always_comb begin
      phase_d = phase_q;
      row_d   = row_q;
      cnt_d   = cnt_q;
      if (!bus.enable) begin
         phase_d = PH_BLANK;
         row_d   = 3'd0;
         cnt_d   = '0;
      end else if (phase_q == PH_BLANK) begin
         if (last_blank) begin
            phase_d = PH_DRIVE;
            cnt_d   = '0;
         end else begin
            cnt_d   = cnt_q + CNT_W'(1);
         end
      end else begin
         if (last_drive) begin
            phase_d = PH_BLANK;
            cnt_d   = '0;
            row_d   = row_q + 3'd1;
         end else begin
            cnt_d   = cnt_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      frame_d    = frame_q;
      bird_row_d = bird_row_q;
      bird_en_d  = bird_en_q;
      if (capture) begin
         frame_d    = bus.pipes;
         bird_row_d = bus.bird_row;
         bird_en_d  = bus.bird_en;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q    <= PH_BLANK;
         row_q      <= 3'd0;
         cnt_q      <= '0;
         frame_q    <= '0;
         bird_row_q <= 3'd0;
         bird_en_q  <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         row_q      <= row_d;
         cnt_q      <= cnt_d;
         frame_q    <= frame_d;
         bird_row_q <= bird_row_d;
         bird_en_q  <= bird_en_d;
      end
   end

   matrix_row_slice u_red_slice (
      .frame (frame_q),
      .row   (row_q),
      .col   (red_slice)
   );

   // Pure decode of registered state and snapshot; nothing from the inputs.
   always_comb begin
      bus.row_sel    = 8'd0;
      bus.red_col    = 8'd0;
      bus.grn_col    = 8'd0;
      bus.frame_done = 1'b0;
      if (phase_q == PH_DRIVE) begin
         bus.row_sel    = 8'd1 << row_q;
         bus.red_col    = red_slice;
         if (bird_en_q && (bird_row_q == row_q))
            bus.grn_col = 8'd1 << BIRD_COL;
         bus.frame_done = last_drive && (row_q == 3'd7);
      end
   end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Row scanner bench: directed test-plan scenarios then random inputs, all
// checked each cycle against a frame-position reference model.
module tb_led_matrix_scan;
   import flappy_pkg::*;

   localparam int DW = 4;
   localparam int BL = 2;
   localparam int BC = 1;
   localparam int RP = BL + DW;
   localparam int FP = 8 * RP;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   led_matrix_scan_if bus ();

   led_matrix_scan #(.DWELL(DW), .BLANK(BL), .BIRD_COL(BC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Model: k = position within the frame (enabled cycles since scan start).
   int         k;
   matrix_t    s_pipes;
   logic [2:0] s_brow;
   logic       s_ben;

   task automatic step(input string tag);
      int         row, o;
      logic       drv;
      logic [7:0] e_row, e_red, e_grn;
      logic       e_fd;
      @(posedge clk);
      if (reset) begin
         k = 0; s_pipes = '0; s_brow = 3'd0; s_ben = 1'b0;
      end else if (!bus.enable) begin
         k = 0;
      end else begin
         if (k == 0) begin
            s_pipes = bus.pipes; s_brow = bus.bird_row; s_ben = bus.bird_en;
         end
         k = (k + 1) % FP;
      end
      #1;
      row   = k / RP;
      o     = k % RP;
      drv   = (o >= BL);
      e_row = drv ? 8'(1 << row) : 8'd0;
      e_red = 8'd0;
      for (int c = 0; c < 8; c++) if (drv) e_red[c] = s_pipes[c][row];
      e_grn = (drv && s_ben && (int'(s_brow) == row)) ? 8'(1 << BC) : 8'd0;
      e_fd  = drv && (o == RP - 1) && (row == 7);
      chk({tag, ".row_sel"},    32'(bus.row_sel),    32'(e_row));
      chk({tag, ".red_col"},    32'(bus.red_col),    32'(e_red));
      chk({tag, ".grn_col"},    32'(bus.grn_col),    32'(e_grn));
      chk({tag, ".frame_done"}, 32'(bus.frame_done), 32'(e_fd));
      chk({tag, ".onehot"},     32'($countones(bus.row_sel) <= 1), 32'd1);
      @(negedge clk);
   endtask

   initial begin
      k = 0; s_pipes = '0; s_brow = 3'd0; s_ben = 1'b0;
      reset = 1'b1;
      bus.enable = 1'b0; bus.pipes = '0; bus.bird_row = 3'd0; bus.bird_en = 1'b0;
      @(negedge clk);
      repeat (3) step("reset");

      reset = 1'b0; bus.enable = 1'b1;
      repeat (2 * FP) step("blank_frame");

      bus.pipes[3] = 8'b1000_0001;
      repeat (2 * FP) step("pipe_col3");

      bus.pipes = '0; bus.pipes[1] = 8'h20; bus.bird_en = 1'b1; bus.bird_row = 3'd5;
      repeat (2 * FP) step("bird_overlap");

      // Mid-frame pipe change must not show until the next frame.
      bus.pipes = '0; bus.bird_en = 1'b0;
      while (k != 0) step("sync");
      repeat (20) step("tear_pre");
      for (int c = 0; c < 8; c++) bus.pipes[c] = 8'hFF;
      repeat (FP) step("tear_post");

      // Enable drop during row 3 drive.
      while (k != 3 * RP + BL + 1) step("to_row3");
      bus.enable = 1'b0;
      repeat (5) step("en_low");
      bus.enable = 1'b1;
      repeat (RP + 2) step("re_en");

      // Reset during row 6 drive.
      while (k != 6 * RP + BL + 1) step("to_row6");
      reset = 1'b1; bus.pipes = '0;
      step("mid_reset");
      reset = 1'b0;
      repeat (FP) step("post_reset");

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0)
            for (int c = 0; c < 8; c++) bus.pipes[c] = 8'($urandom);
         if ($urandom_range(15) == 0) begin
            bus.bird_row = 3'($urandom);
            bus.bird_en  = 1'($urandom);
         end
         bus.enable = ($urandom_range(39) != 0);
         reset      = ($urandom_range(199) == 0);
         step("random");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/led_matrix_scan.md
Name: led_matrix_scan

Overview:
- Reader/display end of the scrolling pipe field: takes the 8x8 column-ordered pipe frame produced by the horizontal scroller, plus the bird position, and drives the dual-colour 8x8 LED matrix by time-multiplexed row scanning.
- Pipes are shown on the red plane and the bird on the green plane; overlap lights both (orange).
- Takes a per-frame snapshot so a scroller update never tears a displayed frame.

Parameters:
- DWELL, 1024, clk cycles each row is driven (>=1).
- BLANK, 16, clk cycles all columns off before each row (anti-ghosting, >=1).
- BIRD_COL, 1, fixed matrix column the bird occupies (0..7).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- enable  input  1  scan enable; low = display dark, scan parked
- pipes  input  [7:0][7:0]  frame; pipes[c][r] = LED at column c (0 = leftmost), row r (0 = top)
- bird_row  input  3  bird row index
- bird_en  input  1  bird visible
- row_sel  output  8  one-hot active-high row drive
- red_col  output  8  red column drive, bit c = column c
- grn_col  output  8  green column drive, bit c = column c
- frame_done  output  1  one-cycle pulse on the last drive cycle of row 7

Behaviour:
- State register: phase {BLANK, DRIVE}, row[2:0], cnt (width fits max(DWELL, BLANK)).
- Snapshot register: frame buffer (8x8), bird row, bird enable.
- All outputs are decoded only from registered state and the snapshot. There is no combinational path from inputs to outputs.
- Reset: phase=BLANK, row=0, cnt=0, snapshot cleared.
  - row_sel=0, red_col=0, grn_col=0, frame_done=0.
- Snapshot: captured on every clk edge where enable && phase==BLANK && row==0 && cnt==0. Buffer is valid from the next cycle, always before the first DRIVE of row 0. Input changes at any other time are ignored until the next frame.
- BLANK phase:
  - Outputs all 0.
  - cnt increments each cycle.
  - At cnt==BLANK-1: go to DRIVE, cnt=0.
- DRIVE phase:
  - row_sel = 1<<row.
  - red_col[c] = frame[c][row].
  - grn_col[c] = (c==BIRD_COL) && bird_en_s && (bird_row_s==row).
  - At cnt==DWELL-1: go to BLANK, cnt=0, row=row+1 (wraps 7->0).
  - frame_done=1 during that cycle only when row==7.
- Timing:
  - Row period = BLANK+DWELL cycles; frame period = 8*(BLANK+DWELL).
  - First DRIVE of row 0 is BLANK cycles after the first enabled cycle out of reset.
- enable low (any cycle, any phase): on the next edge, phase=BLANK, row=0, cnt=0, and all outputs read 0 from that cycle on. The snapshot is held. On re-enable, scanning restarts at row 0 with a fresh snapshot.
- reset mid-frame: same as the reset values above; the snapshot is cleared.
- Simultaneous enable rise and pipes change: the snapshot takes the pipes value present on the capture edge.
- At most one row_sel bit is ever set; row_sel and column drives change on the same edge.

Decomposition:
- flappy_pkg holds:
  - typedef matrix_t = logic [7:0][7:0] (shared with the scroller);
  - scan phase enum {BLANK, DRIVE};
  - MATRIX_DIM = 8.
- One sub-module, matrix_row_slice: combinational (matrix_t frame, row index) -> 8-bit column vector, i.e. the transpose slice. Instantiated once for the red plane.

Test Plan (DWELL=4, BLANK=2: row period 6, frame 48):
- Reset held 3 cycles, then enable=1 with pipes all 0, bird_en=0 -> all outputs 0 for cycles 0-1; row_sel=8'h01 for cycles 2-5; 8'h02 at cycle 8; frame_done high only at cycle 47; pattern repeats every 48 cycles.
- pipes[3]=8'b1000_0001, all other columns 0 -> during row 0 and row 7 DRIVE, red_col=8'b0000_1000; red_col=0 on rows 1-6 and in every BLANK.
- bird_en=1, bird_row=5, BIRD_COL=1, pipes[1]=8'h20 -> row 5 DRIVE shows red_col=8'h02 and grn_col=8'h02 (overlap); no other row has grn_col nonzero.
- Change pipes from 8'h00 columns to all 8'hFF at cycle 20 (mid-frame) -> red_col stays 0 until the next frame; the first DRIVE of row 0 in the next frame shows red_col=8'hFF.
- Drop enable during row 3 DRIVE for 5 cycles -> outputs 0 the cycle after the drop. After re-enable: 2 blank cycles, then row_sel=8'h01.
- Assert reset during row 6 DRIVE -> next cycle all outputs 0, snapshot cleared; after release, row 0 is driven with red_col=0 unless pipes is nonzero at the capture edge.
